// File: rtl/mont_arbiter_pkg.sv
// Shared constants and FSM encoding for the Montgomery multiplier arbiter.
package mont_arbiter_pkg;

   localparam int unsigned WIDTH_DEF   = 512;
   localparam int unsigned TIMEOUT_DEF = 4095;
   localparam int unsigned CNT_W       = 16;
   localparam int unsigned NREQ        = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_BUSY  = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

endpackage

// File: rtl/mont_arbiter_if.sv
// Requester and multiplier-side signals of the arbiter, bundled as one bus.
interface mont_arbiter_if
   import mont_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
);

   logic [NREQ-1:0]  req;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] b0;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic [WIDTH-1:0] modulus;
   logic [NREQ-1:0]  grant;
   logic [NREQ-1:0]  done;
   logic             err;
   logic [WIDTH-1:0] result;
   logic             mont_resetn;
   logic             mont_start;
   logic [WIDTH-1:0] mont_in_a;
   logic [WIDTH-1:0] mont_in_b;
   logic [WIDTH-1:0] mont_in_m;
   logic [WIDTH-1:0] mont_result;
   logic             mont_done;

   // Arbiter side
   modport slave (
      input  req, a0, b0, a1, b1, modulus, mont_result, mont_done,
      output grant, done, err, result, mont_resetn, mont_start,
             mont_in_a, mont_in_b, mont_in_m
   );

   // Requesters plus multiplier side
   modport master (
      output req, a0, b0, a1, b1, modulus, mont_result, mont_done,
      input  grant, done, err, result, mont_resetn, mont_start,
             mont_in_a, mont_in_b, mont_in_m
   );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to ptr.
module rr_pick2
   import mont_arbiter_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic            ptr,
   output logic [NREQ-1:0] gnt
);

   // One-hot winner selection
   always_comb begin
      gnt = '0;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr ? 2'b10 : 2'b01;
         default: gnt = '0;
      endcase
   end

endmodule

// File: rtl/mont_arbiter.sv
// Shares one external Montgomery multiplier between two requesters with
// round-robin arbitration and a BUSY watchdog.
module mont_arbiter
   import mont_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          resetn,
   mont_arbiter_if.slave bus
);

   state_e           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic             err_q, err_d;
   logic             mont_start_q, mont_start_d;
   logic             mont_resetn_q, mont_resetn_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] in_a_q, in_a_d;
   logic [WIDTH-1:0] in_b_q, in_b_d;
   logic [WIDTH-1:0] in_m_q, in_m_d;
   logic [NREQ-1:0]  pick;
   logic             timeout_hit;

   rr_pick2 u_pick (
      .req (bus.req),
      .ptr (ptr_q),
      .gnt (pick)
   );

   // Counter holds the number of BUSY cycles that passed without completion
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));

   // Next state; every registered output is computed for the state being entered
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      grant_d       = grant_q;
      done_d        = '0;
      err_d         = 1'b0;
      mont_start_d  = 1'b0;
      mont_resetn_d = 1'b0;
      cnt_d         = cnt_q;
      result_d      = result_q;
      in_a_d        = in_a_q;
      in_b_d        = in_b_q;
      in_m_d        = in_m_q;
      case (state_q)
         ST_IDLE: begin
            grant_d = pick;
            if (bus.req != '0) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            in_a_d        = grant_q[1] ? bus.a1 : bus.a0;
            in_b_d        = grant_q[1] ? bus.b1 : bus.b0;
            in_m_d        = bus.modulus;
            mont_start_d  = 1'b1;
            mont_resetn_d = 1'b1;
            state_d       = ST_START;
         end
         ST_START: begin
            cnt_d         = '0;
            mont_resetn_d = 1'b1;
            state_d       = ST_BUSY;
         end
         ST_BUSY: begin
            mont_resetn_d = 1'b1;
            if (bus.mont_done) begin
               // completion wins over a coincident timeout
               result_d = bus.mont_result;
               done_d   = grant_q;
               ptr_d    = grant_q[0];
               state_d  = ST_RESP;
            end else if (timeout_hit) begin
               done_d        = grant_q;
               err_d         = 1'b1;
               mont_resetn_d = 1'b0;
               ptr_d         = grant_q[0];
               state_d       = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         ptr_q         <= 1'b0;
         grant_q       <= '0;
         done_q        <= '0;
         err_q         <= 1'b0;
         mont_start_q  <= 1'b0;
         mont_resetn_q <= 1'b0;
         cnt_q         <= '0;
         result_q      <= '0;
         in_a_q        <= '0;
         in_b_q        <= '0;
         in_m_q        <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_q       <= grant_d;
         done_q        <= done_d;
         err_q         <= err_d;
         mont_start_q  <= mont_start_d;
         mont_resetn_q <= mont_resetn_d;
         cnt_q         <= cnt_d;
         result_q      <= result_d;
         in_a_q        <= in_a_d;
         in_b_q        <= in_b_d;
         in_m_q        <= in_m_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
   assign bus.result      = result_q;
   assign bus.mont_start  = mont_start_q;
   assign bus.mont_resetn = mont_resetn_q;
   assign bus.mont_in_a   = in_a_q;
   assign bus.mont_in_b   = in_b_q;
   assign bus.mont_in_m   = in_m_q;

endmodule

// File: tb/tb_mont_arbiter.sv
// Bench for mont_arbiter with an adder stub standing in for the multiplier.
module tb_mont_arbiter;

   localparam int unsigned W  = 32;
   localparam int unsigned TO = 20;

   logic clk;
   logic resetn;
   int   checks   = 0;
   int   failures = 0;

   mont_arbiter_if #(.WIDTH(W)) bus ();

   mont_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub multiplier: result = a+b, mont_done shows stub_lat+1 cycles after start
   int   stub_lat   = 10;
   bit   stub_never = 1'b0;
   int   stub_cnt   = 0;
   logic stub_done  = 1'b0;

   always @(posedge clk) begin
      if (bus.mont_resetn !== 1'b1) begin
         stub_cnt  <= 0;
         stub_done <= 1'b0;
      end else if (bus.mont_start === 1'b1) begin
         stub_cnt  <= stub_never ? 0 : stub_lat;
         stub_done <= 1'b0;
      end else begin
         stub_done <= (stub_cnt == 1);
         if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
      end
   end

   assign bus.mont_done   = stub_done;
   assign bus.mont_result = bus.mont_in_a + bus.mont_in_b;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn     = 1'b0;
      bus.req    = 2'b00;
      stub_never = 1'b0;
      tick();
      resetn     = 1'b1;
   endtask

   // Advance until a done pulse or maxc cycles; k=0 is the call cycle
   task automatic wait_done(input int maxc, output int st, output int dn,
                            output logic [1:0] d, output logic e,
                            output logic [W-1:0] r, output logic mr,
                            output logic [1:0] g);
      st = -1; dn = -1; d = 2'b00; e = 1'b0; r = '0; mr = 1'b1; g = 2'b00;
      for (int k = 1; k <= maxc && dn < 0; k++) begin
         tick();
         if (bus.mont_start === 1'b1 && st < 0) st = k;
         if (bus.done !== 2'b00) begin
            dn = k; d = bus.done; e = bus.err; r = bus.result;
            mr = bus.mont_resetn; g = bus.grant;
         end
      end
   endtask

   task automatic test_reset();
      resetn  = 1'b0;
      bus.req = 2'b11;
      tick();
      checks++;
      if ({bus.grant, bus.done, bus.err, bus.mont_start, bus.mont_resetn} !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=%b",
                  {bus.grant, bus.done, bus.err, bus.mont_start, bus.mont_resetn}, 7'b0);
      end
      checks++;
      if (bus.result !== '0 || bus.mont_in_a !== '0 || bus.mont_in_b !== '0 || bus.mont_in_m !== '0) begin
         failures++;
         $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bus.result, bus.mont_in_a,
                  bus.mont_in_b, bus.mont_in_m);
      end
      tick();
      checks++;
      if (bus.grant !== 2'b00) begin
         failures++;
         $display("FAIL reset_hold_grant got=%b exp=00", bus.grant);
      end
      resetn  = 1'b1;
      bus.req = 2'b00;
   endtask

   task automatic test_single();
      int st, dn; logic [1:0] d, g; logic e, mr; logic [W-1:0] r;
      do_reset();
      bus.modulus = 32'd99; bus.a0 = 32'd5; bus.b0 = 32'd7; stub_lat = 10;
      bus.req = 2'b01;
      wait_done(40, st, dn, d, e, r, mr, g);
      bus.req = 2'b00;
      checks++;
      if (st !== 2) begin failures++; $display("FAIL single_start got=%0d exp=2", st); end
      checks++;
      if (dn !== 14) begin failures++; $display("FAIL single_done_cycle got=%0d exp=14", dn); end
      checks++;
      if (d !== 2'b01 || g !== 2'b01 || e !== 1'b0) begin
         failures++; $display("FAIL single_flags got=done %b grant %b err %b exp=01 01 0", d, g, e);
      end
      checks++;
      if (r !== 32'd12) begin failures++; $display("FAIL single_result got=%0d exp=12", r); end
      checks++;
      if (bus.mont_in_m !== 32'd99) begin failures++; $display("FAIL single_mod got=%0d exp=99", bus.mont_in_m); end
      tick();
      checks++;
      if (bus.done !== 2'b00 || bus.grant !== 2'b00 || bus.result !== 32'd12) begin
         failures++;
         $display("FAIL single_after got=done %b grant %b result %0d exp=00 00 12",
                  bus.done, bus.grant, bus.result);
      end
   endtask

   task automatic test_alternate();
      int st, dn; logic [1:0] d, g, exp_d; logic e, mr; logic [W-1:0] r, exp_r;
      do_reset();
      bus.a0 = 32'd1; bus.b0 = 32'd2; bus.a1 = 32'd10; bus.b1 = 32'd20; stub_lat = 10;
      bus.req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         exp_d = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_r = (i % 2 == 0) ? 32'd3 : 32'd30;
         wait_done(40, st, dn, d, e, r, mr, g);
         checks++;
         if (d !== exp_d || g !== exp_d || r !== exp_r || e !== 1'b0 || dn !== ((i == 0) ? 14 : 15)) begin
            failures++;
            $display("FAIL alternate_op%0d got=done %b grant %b result %0d err %b at %0d exp=%b %b %0d 0 at %0d",
                     i, d, g, r, e, dn, exp_d, exp_d, exp_r, (i == 0) ? 14 : 15);
         end
      end
      bus.req = 2'b00;
   endtask

   task automatic test_timeout();
      int st, dn; logic [1:0] d, g; logic e, mr; logic [W-1:0] r;
      do_reset();
      bus.a0 = 32'd3; bus.b0 = 32'd4; stub_lat = 10; bus.req = 2'b01;
      wait_done(40, st, dn, d, e, r, mr, g);
      bus.req = 2'b00;
      tick();
      stub_never = 1'b1;
      bus.a1 = 32'd50; bus.b1 = 32'd60; bus.req = 2'b10;
      wait_done(60, st, dn, d, e, r, mr, g);
      bus.req = 2'b00;
      checks++;
      if (dn !== TO + 4 || st !== 2) begin
         failures++; $display("FAIL timeout_cycle got=start %0d done %0d exp=2 %0d", st, dn, TO + 4);
      end
      checks++;
      if (d !== 2'b10 || e !== 1'b1) begin
         failures++; $display("FAIL timeout_flags got=done %b err %b exp=10 1", d, e);
      end
      checks++;
      if (r !== 32'd7) begin failures++; $display("FAIL timeout_result_kept got=%0d exp=7", r); end
      checks++;
      if (mr !== 1'b0) begin failures++; $display("FAIL timeout_mont_resetn got=%b exp=0", mr); end
      stub_never = 1'b0;
   endtask

   task automatic test_collision();
      int st, dn; logic [1:0] d, g; logic e, mr; logic [W-1:0] r;
      do_reset();
      bus.a0 = 32'd40; bus.b0 = 32'd2; stub_lat = TO; bus.req = 2'b01;
      wait_done(60, st, dn, d, e, r, mr, g);
      bus.req = 2'b00;
      checks++;
      if (dn !== TO + 4 || d !== 2'b01 || e !== 1'b0 || r !== 32'd42 || mr !== 1'b1) begin
         failures++;
         $display("FAIL collision got=at %0d done %b err %b result %0d mrn %b exp=at %0d 01 0 42 1",
                  dn, d, e, r, mr, TO + 4);
      end
      tick();
      bus.a1 = 32'd8; bus.b1 = 32'd9; stub_lat = TO + 1; bus.req = 2'b10;
      wait_done(60, st, dn, d, e, r, mr, g);
      bus.req = 2'b00;
      checks++;
      if (dn !== TO + 4 || d !== 2'b10 || e !== 1'b1 || r !== 32'd42) begin
         failures++;
         $display("FAIL just_late got=at %0d done %b err %b result %0d exp=at %0d 10 1 42",
                  dn, d, e, r, TO + 4);
      end
   endtask

   task automatic test_operand_change();
      int st, dn; logic [1:0] d, g; logic e, mr; logic [W-1:0] r;
      do_reset();
      bus.modulus = 32'd77; bus.a1 = 32'd100; bus.b1 = 32'd23; stub_lat = 10;
      bus.req = 2'b10;
      tick();
      tick();
      bus.a1 = $urandom; bus.b1 = $urandom; bus.modulus = $urandom;
      bus.req = 2'b00;
      wait_done(40, st, dn, d, e, r, mr, g);
      checks++;
      if (dn !== 12 || d !== 2'b10 || r !== 32'd123 || e !== 1'b0) begin
         failures++;
         $display("FAIL operand_change got=at %0d done %b result %0d err %b exp=at 12 10 123 0",
                  dn, d, r, e);
      end
      checks++;
      if (bus.mont_in_m !== 32'd77) begin
         failures++; $display("FAIL operand_change_mod got=%0d exp=77", bus.mont_in_m);
      end
   endtask

   task automatic test_reset_busy();
      int st, dn; logic [1:0] d, g, seen; logic e, mr; logic [W-1:0] r;
      do_reset();
      bus.a0 = 32'd5; bus.b0 = 32'd7; stub_lat = 10; bus.req = 2'b01;
      wait_done(40, st, dn, d, e, r, mr, g);
      bus.req = 2'b00;
      tick();
      bus.a0 = 32'd8; bus.b0 = 32'd9; bus.req = 2'b01;
      seen = 2'b00;
      for (int k = 1; k <= 7; k++) begin
         tick();
         seen = seen | bus.done;
      end
      resetn = 1'b0;
      tick();
      seen = seen | bus.done;
      checks++;
      if ({bus.grant, bus.done, bus.err, bus.mont_start, bus.mont_resetn} !== 7'b0 || seen !== 2'b00) begin
         failures++;
         $display("FAIL busy_reset_ctrl got=%b seen %b exp=0000000 seen 00",
                  {bus.grant, bus.done, bus.err, bus.mont_start, bus.mont_resetn}, seen);
      end
      checks++;
      if (bus.result !== '0 || bus.mont_in_a !== '0) begin
         failures++; $display("FAIL busy_reset_data got=%0d/%0d exp=0/0", bus.result, bus.mont_in_a);
      end
      resetn = 1'b1;
      bus.a1 = 32'd20; bus.b1 = 32'd22; bus.req = 2'b10;
      wait_done(40, st, dn, d, e, r, mr, g);
      bus.req = 2'b00;
      checks++;
      if (dn !== 14 || d !== 2'b10 || r !== 32'd42 || e !== 1'b0) begin
         failures++;
         $display("FAIL busy_reset_next got=at %0d done %b result %0d err %b exp=at 14 10 42 0",
                  dn, d, r, e);
      end
   endtask

   // Transaction-level reference: winner, completion cycle and result from the rules
   task automatic test_random();
      logic [1:0]   rq, exp_g;
      logic [W-1:0] opa [2];
      logic [W-1:0] opb [2];
      logic [W-1:0] mod_v, exp_res, last_res;
      logic [6:0]   exp_v, got_v;
      int busy_until, t_arb, winner, lat;
      bit ptr, active, exp_err;
      do_reset();
      mod_v = $urandom; bus.modulus = mod_v;
      rq = 2'b00; busy_until = -1; t_arb = -10; winner = 0; lat = 1;
      ptr = 1'b0; active = 1'b0; exp_err = 1'b0; last_res = '0; exp_res = '0;
      for (int i = 0; i < 2; i++) begin opa[i] = '0; opb[i] = '0; end
      for (int n = 0; n < 2500; n++) begin
         exp_g = active ? 2'(1 << winner) : 2'b00;
         exp_v = {exp_g, (active && n == busy_until) ? exp_g : 2'b00,
                  active && n == busy_until && exp_err,
                  active && n == t_arb + 2,
                  active && n >= t_arb + 2 && !(n == busy_until && exp_err)};
         got_v = {bus.grant, bus.done, bus.err, bus.mont_start, bus.mont_resetn};
         checks++;
         if (got_v !== exp_v) begin
            failures++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", n, got_v, exp_v);
         end
         if (active && n == t_arb + 2) begin
            checks++;
            if ({bus.mont_in_a, bus.mont_in_b, bus.mont_in_m} !== {opa[winner], opb[winner], mod_v}) begin
               failures++;
               $display("FAIL rand_operands cyc=%0d got=%h %h %h exp=%h %h %h", n, bus.mont_in_a,
                        bus.mont_in_b, bus.mont_in_m, opa[winner], opb[winner], mod_v);
            end
         end
         if (active && n == busy_until) begin
            if (!exp_err) last_res = exp_res;
            checks++;
            if (bus.result !== last_res) begin
               failures++; $display("FAIL rand_result cyc=%0d got=%h exp=%h", n, bus.result, last_res);
            end
            active = 1'b0;
            rq[winner] = 1'b0;
         end
         for (int i = 0; i < 2; i++) begin
            if (!rq[i] && $urandom_range(0, 3) == 0) begin
               opa[i] = $urandom; opb[i] = $urandom; rq[i] = 1'b1;
            end
         end
         bus.a0 = opa[0]; bus.b0 = opb[0]; bus.a1 = opa[1]; bus.b1 = opb[1];
         bus.req = rq;
         if (!active && n > busy_until && rq != 2'b00) begin
            winner  = (rq == 2'b11) ? int'(ptr) : (rq[1] ? 1 : 0);
            ptr     = (winner == 0);
            lat     = $urandom_range(1, TO + 3);
            exp_err = (lat > TO);
            exp_res = opa[winner] + opb[winner];
            stub_lat   = lat;
            t_arb      = n;
            busy_until = n + 4 + (exp_err ? TO : lat);
            active     = 1'b1;
         end
         tick();
      end
      bus.req = 2'b00;
   endtask

   initial begin
      resetn = 1'b0;
      bus.req = 2'b00;
      bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0; bus.modulus = '0;
      test_reset();
      test_single();
      test_alternate();
      test_timeout();
      test_collision();
      test_operand_change();
      test_reset_busy();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mont_arbiter.md
MONT_ARBITER -- requirements
Module: mont_arbiter

Interface
REQ-001 Parameter WIDTH, 512, operand/modulus/result width in bits.
REQ-002 Parameter TIMEOUT, 4095, maximum BUSY cycles before abort; range 1..65535.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 req  input  2  per-requester request level; held high until the matching done pulse.
REQ-006 a0, b0 / a1, b1  input  WIDTH each  requester operands; stable while req bit high.
REQ-007 modulus  input  WIDTH  shared modulus; stable while any req is high.
REQ-008 grant  output  2  one-hot; marks the requester currently owning the multiplier.
REQ-009 done  output  2  one-cycle completion pulse per requester.
REQ-010 err  output  1  high with a done pulse when that operation timed out.
REQ-011 result  output  WIDTH  registered result; valid while done is high, held until the next capture.
REQ-012 mont_resetn  output  1  multiplier reset, active-low.
REQ-013 mont_start  output  1  multiplier start pulse.
REQ-014 mont_in_a, mont_in_b, mont_in_m  output  WIDTH each  registered multiplier operands.
REQ-015 mont_result  input  WIDTH  multiplier result.
REQ-016 mont_done  input  1  multiplier completion flag.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, START, BUSY, RESP.
REQ-018 IDLE: when any req bit is high, the block SHALL pick the winner, set grant one-hot and go to LOAD; otherwise it stays in IDLE with grant=0.
REQ-019 Arbitration SHALL be round-robin: a pointer bit (reset 0) names the preferred requester; a lone requester always wins; the pointer SHALL move to the other requester when RESP is entered.
REQ-020 LOAD: mont_resetn=0 for exactly one cycle; mont_in_a/b/m SHALL capture the winner's a, b and modulus; next state START.
REQ-021 START: mont_start=1 for exactly one cycle; the BUSY cycle counter clears to 0; next state BUSY.
REQ-022 BUSY: mont_done sampled 1 SHALL capture mont_result into result and go to RESP with err=0.
REQ-023 BUSY: each cycle without mont_done SHALL increment the counter; when the counter reaches TIMEOUT, go to RESP with err=1, leave result unchanged, and drive mont_resetn=0 for that cycle.
REQ-024 If mont_done arrives in the same cycle the counter reaches TIMEOUT, completion SHALL win (err=0).
REQ-025 RESP: done[winner]=1 and err valid for one cycle; grant remains set; next state IDLE.
REQ-026 mont_resetn SHALL be 1 in START, BUSY and RESP, except as stated in REQ-023; in IDLE it SHALL be 0.
REQ-027 Latency: req seen in IDLE at cycle T gives mont_start=1 at T+2; done pulses the cycle after mont_done is sampled in BUSY.
REQ-028 Operands SHALL be sampled only in LOAD; requester input changes after LOAD SHALL NOT affect the operation in flight.
REQ-029 A req bit deasserted before its done pulse is a protocol violation; the block SHALL still complete and pulse done.
REQ-030 Back-to-back: a req high in the IDLE cycle following RESP SHALL be arbitrated with no extra idle cycle.

Reset
REQ-031 With resetn=0, on the next clock edge: state=IDLE, pointer=0, grant=0, done=0, err=0, mont_start=0, mont_resetn=0, counter=0, result=0, mont_in_a/b/m=0.
REQ-032 Reset in any state, including mid-BUSY, SHALL abort the operation without a done pulse.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding and the default WIDTH/TIMEOUT constants.
REQ-034 The round-robin pick SHALL be one sub-module, rr_pick2 (inputs req[1:0] and ptr; output one-hot gnt).
REQ-035 The multiplier SHALL be instantiated outside this block and connected through the mont_* ports.

Verification (stub multiplier: fixed 10-cycle latency, result = a+b)
REQ-036 After reset, req=01, a0=5, b0=7 -> mont_start at T+2, done=01 with result=12 and err=0 at T+14.
REQ-037 Both req high in IDLE after reset -> requester 0 served first, then requester 1; grant sequence 01, 10.
REQ-038 Both req held high for 4 operations -> grants strictly alternate 01,10,01,10; no done is lost.
REQ-039 Stub never raises mont_done, TIMEOUT=20 -> done pulses with err=1 exactly 20 BUSY cycles after START, result unchanged, mont_resetn=0 in that cycle.
REQ-040 resetn=0 for one cycle at BUSY cycle 5 -> no done pulse, all outputs at reset values, then a new req=10 is served normally.
REQ-041 mont_done on the same cycle the counter reaches TIMEOUT (stub latency=TIMEOUT) -> err=0 and result captured.
